fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 106 ++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: circular buffer of fetched instructions between fetch and decode.
// Each entry carries the instruction word, its PC and the predictor taken flag.
// Optional same-cycle bypass from enq_* to deq_* when the queue is empty:
// enabled by defining FETCH_QUEUE_BYPASS_EN (default build: no bypass).
module fetch_queue #(
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enq_valid,
    input  logic [31:0]             enq_inst,
    input  logic [31:0]             enq_pc,
    input  logic                    enq_bp_taken,
    input  logic                    flush,
    input  logic                    deq_ready,
    output logic                    deq_valid,
    output logic [31:0]             deq_inst,
    output logic [31:0]             deq_pc,
    output logic                    deq_bp_taken,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        bp_taken;
    } entry_t;

    entry_t      mem [DEPTH];
    logic [AW:0] head;
    logic [AW:0] tail;
    logic        empty;
    logic        enq_fire;
    logic        deq_fire;
    logic        bypass_fire;
    entry_t      head_entry;

    // Occupancy flags come from the registered pointers; the extra wrap bit
    // distinguishes a full queue from an empty one when the indices match.
    assign empty = (head == tail);
    assign full  = !rst && (head[AW-1:0] == tail[AW-1:0]) && (head[AW] != tail[AW]);
    assign count = rst ? '0 : (tail - head);

`ifdef FETCH_QUEUE_BYPASS_EN
    // An empty queue forwards the incoming instruction straight to decode;
    // if decode takes it this cycle, nothing is written.
    assign bypass_fire = empty && enq_valid && !flush && deq_ready;
    assign deq_valid   = !rst && !flush && (!empty || enq_valid);
`else
    assign bypass_fire = 1'b0;
    assign deq_valid   = !rst && !flush && !empty;
`endif

    // A full queue drops enq_valid even if the head leaves this cycle;
    // fetch is frozen by full and re-presents the instruction.
    assign enq_fire = enq_valid && !full && !flush && !bypass_fire;
    assign deq_fire = deq_valid && deq_ready && !flush && !empty;

    // Head entry selection; outputs are zeroed whenever no valid entry is shown.
    always_comb begin
        head_entry = mem[head[AW-1:0]];
`ifdef FETCH_QUEUE_BYPASS_EN
        if (empty) begin
            head_entry = '{inst: enq_inst, pc: enq_pc, bp_taken: enq_bp_taken};
        end
`endif
        if (!deq_valid) begin
            head_entry = '0;
        end
        deq_inst     = head_entry.inst;
        deq_pc       = head_entry.pc;
        deq_bp_taken = head_entry.bp_taken;
    end

    // Pointer update: reset beats flush, flush beats enqueue and dequeue.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            head <= '0;
            tail <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (enq_fire) begin
                tail <= tail + PTR_ONE;
            end
            if (deq_fire) begin
                head <= head + PTR_ONE;
            end
        end
    end

    // Entry storage written at the tail slot on each accepted enqueue.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; stale slots are never visible because deq_* is masked when invalid.
        if (enq_fire) begin
            mem[tail[AW-1:0]] <= '{inst: enq_inst, pc: enq_pc, bp_taken: enq_bp_taken};
        end
    end

endmodule
